uart_word_serializer: RTL and testbench
=======================================

Name: uart_word_serializer

Overview:
- Sits between the debug unit and the UART transmitter.
- Accepts one NB-bit word (PC, register or memory dump) through a valid/ready handshake.
- Slices the word into NB/DATA_BITS bytes and issues one transmitter start pulse per byte. It waits for the transmitter's done pulse before sending the next byte.
- Lets the debug unit hand over whole words instead of sequencing bytes itself.

Parameters:
- NB, 32: word width in bits; must be an integer multiple of DATA_BITS (elaboration error otherwise).
- DATA_BITS, 8: UART byte width.
- MSB_FIRST, 0: 0 sends the least significant byte first; 1 sends the most significant byte first.
- Derived localparam NB_BYTES = NB/DATA_BITS; byte index width = clog2(NB_BYTES), minimum 1.

Ports:
- i_clk  in  1  system clock; all state updates on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_word_valid  in  1  word offered by the debug unit.
- i_word  in  NB  word to send; sampled only on the accept edge.
- o_word_ready  out  1  serializer can accept a word.
- i_uart_tx_done  in  1  one-cycle pulse from the transmitter: current byte fully shifted out.
- o_uart_tx_ready  out  1  one-cycle start pulse to the transmitter.
- o_uart_tx_data  out  DATA_BITS  byte for the transmitter; stable from its start pulse until the matching done pulse.
- o_busy  out  1  high while a word is in progress.
- o_word_done  out  1  one-cycle pulse after the last byte's done.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - state=IDLE, shift register=0, byte index=0.
  - o_uart_tx_ready=0, o_uart_tx_data=0, o_busy=0, o_word_done=0, o_word_ready=1.
- States: IDLE, START, WAIT_DONE, FINISH. All outputs are registered or decoded from state only; no input-to-output combinational path.
- IDLE:
  - o_word_ready=1, o_busy=0.
  - On an edge with i_word_valid=1: latch i_word into the shift register, index=0, go to START.
  - i_uart_tx_done in IDLE is ignored.
- START (exactly one cycle):
  - o_uart_tx_ready=1.
  - o_uart_tx_data = current byte: bits [DATA_BITS-1:0] of the shift register if MSB_FIRST=0, bits [NB-1:NB-DATA_BITS] if MSB_FIRST=1.
  - Always go to WAIT_DONE. A done pulse arriving in START is stale and ignored.
- WAIT_DONE:
  - o_uart_tx_ready=0; o_uart_tx_data held.
  - On i_uart_tx_done=1:
    - If index==NB_BYTES-1, go to FINISH.
    - Otherwise shift the register by DATA_BITS toward the sent end (zero fill), index+1, go to START.
  - No timeout; waits indefinitely.
- FINISH (one cycle): o_word_done=1, o_busy=1, then go to IDLE. o_uart_tx_data keeps the last byte.
- o_busy=1 in START, WAIT_DONE and FINISH. o_word_ready=0 in those states; i_word_valid there is ignored and not queued.
- Latency:
  - Accept on edge k gives the first start pulse in cycle k+1.
  - A done pulse on edge d gives the next start pulse in cycle d+1.
  - The done pulse for the last byte gives o_word_done in cycle d+1, and o_word_ready=1 again in cycle d+2.
- Back-to-back words: the minimum gap between words is 1 idle cycle. A word offered in the cycle ready returns is accepted on that edge.
- Reset mid-word:
  - Immediate abort; no further start pulses.
  - The partially sent word is discarded; o_word_done is not pulsed.
  - o_uart_tx_data returns to 0.
- NB_BYTES=1: START then WAIT_DONE then FINISH; no shift.

Test Plan:
- Accept and LSB-first order: MSB_FIRST=0, reset released, i_word=32'h0000FFA3 with valid for 1 cycle, done pulse 20 cycles after each start. Required: accepted; 4 start pulses, each exactly 1 cycle wide, carrying A3, FF, 00, 00 in that order. Each start pulse comes 1 cycle after the previous done. o_word_done comes 1 cycle after the 4th done; o_word_ready returns 1 cycle later.
- MSB-first order: MSB_FIRST=1, i_word=32'h12345678. Required: bytes 12, 34, 56, 78; o_uart_tx_data constant between each start and its done.
- Stale done pulses: pulse i_uart_tx_done while in IDLE, then in the START cycle. Required: no state change in either case; the byte is still awaited in WAIT_DONE.
- Held valid: hold i_word_valid=1 with a new word (32'hDEADBEEF) throughout the first word's transfer. Required: the second word is not sampled until IDLE. It is accepted on the first IDLE edge and sends EF, BE, AD, DE.
- Reset mid-word: assert i_reset=0 after the 2nd byte's done. Required: all outputs at reset values at once (asynchronous, before the next edge), no 3rd start pulse, no o_word_done. After release, a new word 32'h00000001 is sent correctly: 01, 00, 00, 00.
- Parameter variant: NB=16, DATA_BITS=8, i_word=16'hBEEF. Required: exactly 2 bytes, EF then BE; then o_word_done.

Source files
------------

// File: rtl/uart_word_serializer.sv
// uart_word_serializer: slices a word into UART bytes, one start pulse per byte, paced by the transmitter's done pulses
module uart_word_serializer #(
  parameter int NB        = 32,
  parameter int DATA_BITS = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_word_valid,
  input  logic [NB-1:0]        i_word,
  output logic                 o_word_ready,
  input  logic                 i_uart_tx_done,
  output logic                 o_uart_tx_ready,
  output logic [DATA_BITS-1:0] o_uart_tx_data,
  output logic                 o_busy,
  output logic                 o_word_done
);
  localparam int NB_BYTES = NB / DATA_BITS;
  localparam int IDX_W = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_BYTES - 1);
  if (NB % DATA_BITS != 0 || NB_BYTES < 1) begin : g_bad_width
    $error("NB must be a positive multiple of DATA_BITS");
  end
  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, FINISH} state_t;
  state_t state_q, state_d;
  logic [NB-1:0] shift_q, shift_d, shifted;
  logic [IDX_W-1:0] idx_q, idx_d;
  // the byte on the wire always sits at the sent end, so advancing moves the next byte there
  assign shifted = (MSB_FIRST != 0) ? shift_q << DATA_BITS : shift_q >> DATA_BITS;
  // state, word and byte index registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end
  // next state: accept in IDLE, one-cycle START, advance only on done in WAIT_DONE
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (i_word_valid) begin
        state_d = START;
        shift_d = i_word;
        idx_d   = '0;
      end
      START: state_d = WAIT_DONE;
      WAIT_DONE: if (i_uart_tx_done) begin
        if (idx_q == LAST_IDX) state_d = FINISH;
        else begin
          state_d = START;
          shift_d = shifted;
          idx_d   = idx_q + 1'b1;
        end
      end
      FINISH: state_d = IDLE;
    endcase
  end
  // outputs decoded from state and the shift register only, so no input reaches an output combinationally
  always_comb begin
    o_word_ready    = state_q == IDLE;
    o_busy          = state_q != IDLE;
    o_uart_tx_ready = state_q == START;
    o_word_done     = state_q == FINISH;
    o_uart_tx_data  = (MSB_FIRST != 0) ? shift_q[NB-1 -: DATA_BITS] : shift_q[DATA_BITS-1:0];
  end
endmodule

// File: tb/tb_uart_word_serializer.sv
// tb_uart_word_serializer: randomized scenario tasks checked against a byte-sequence model of the serializer
module tb_uart_word_serializer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vld[3];
  logic [31:0] wrd[3];
  logic done[3];
  logic rdy[3], txr[3], busy[3], wdone[3];
  logic [7:0] txd[3];
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  uart_word_serializer #(.NB(32), .DATA_BITS(8), .MSB_FIRST(0)) u_lsb (
    .i_clk(clk), .i_reset(rst_n), .i_word_valid(vld[0]), .i_word(wrd[0]), .o_word_ready(rdy[0]),
    .i_uart_tx_done(done[0]), .o_uart_tx_ready(txr[0]), .o_uart_tx_data(txd[0]), .o_busy(busy[0]), .o_word_done(wdone[0]));
  uart_word_serializer #(.NB(32), .DATA_BITS(8), .MSB_FIRST(1)) u_msb (
    .i_clk(clk), .i_reset(rst_n), .i_word_valid(vld[1]), .i_word(wrd[1]), .o_word_ready(rdy[1]),
    .i_uart_tx_done(done[1]), .o_uart_tx_ready(txr[1]), .o_uart_tx_data(txd[1]), .o_busy(busy[1]), .o_word_done(wdone[1]));
  uart_word_serializer #(.NB(16), .DATA_BITS(8), .MSB_FIRST(0)) u_nb16 (
    .i_clk(clk), .i_reset(rst_n), .i_word_valid(vld[2]), .i_word(wrd[2][15:0]), .o_word_ready(rdy[2]),
    .i_uart_tx_done(done[2]), .o_uart_tx_ready(txr[2]), .o_uart_tx_data(txd[2]), .o_busy(busy[2]), .o_word_done(wdone[2]));

  // Drives one word through unit u and checks every byte against the model's expected sequence.
  // dly>0 fixes the start-to-done distance, otherwise it is random; stale pulses done during the first START;
  // hold keeps valid high with word nxt after the accept; stop_after>0 resets right after that many dones.
  task automatic send_word(input int u, input logic [31:0] w, input int nb, input bit msb, input int dly,
                           input bit stale, input bit hold, input logic [31:0] nxt, input int stop_after);
    logic [7:0] exp_q[$];
    int n;
    for (int k = 0; k < nb; k++) exp_q.push_back(8'(w >> (8 * (msb ? nb - 1 - k : k))));
    n = 0;
    while (rdy[u] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (rdy[u] !== 1'b1) begin
      bad++;
      $display("FAIL ready_timeout u=%0d got=%b exp=1", u, rdy[u]);
      return;
    end
    vld[u] = 1'b1;
    wrd[u] = w;
    @(negedge clk);
    if (hold) wrd[u] = nxt;
    else vld[u] = 1'b0;
    for (int i = 0; i < nb; i++) begin
      total++;
      if (txr[u] !== 1'b1 || txd[u] !== exp_q[i]) begin
        bad++;
        $display("FAIL start_byte u=%0d i=%0d got txr=%b data=%h exp txr=1 data=%h", u, i, txr[u], txd[u], exp_q[i]);
      end
      total++;
      if (busy[u] !== 1'b1 || rdy[u] !== 1'b0 || wdone[u] !== 1'b0) begin
        bad++;
        $display("FAIL start_flags u=%0d i=%0d got busy=%b rdy=%b wdone=%b exp 1 0 0", u, i, busy[u], rdy[u], wdone[u]);
      end
      if (stale && i == 0) done[u] = 1'b1;
      @(negedge clk);
      done[u] = 1'b0;
      n = dly > 0 ? dly : int'($urandom_range(2, 20));
      for (int c = 1; c < n; c++) begin
        total++;
        if (txr[u] !== 1'b0 || txd[u] !== exp_q[i] || busy[u] !== 1'b1) begin
          bad++;
          $display("FAIL wait_hold u=%0d i=%0d c=%0d got txr=%b data=%h busy=%b exp txr=0 data=%h busy=1",
                   u, i, c, txr[u], txd[u], busy[u], exp_q[i]);
        end
        @(negedge clk);
      end
      done[u] = 1'b1;
      if (stop_after == i + 1) begin
        @(posedge clk);
        #1 rst_n = 1'b0;
        done[u] = 1'b0;
        vld[u] = 1'b0;
        #1;
        total++;
        if (txr[u] !== 1'b0 || txd[u] !== 8'h00 || busy[u] !== 1'b0 || wdone[u] !== 1'b0 || rdy[u] !== 1'b1) begin
          bad++;
          $display("FAIL async_reset u=%0d got txr=%b data=%h busy=%b wdone=%b rdy=%b exp 0 00 0 0 1",
                   u, txr[u], txd[u], busy[u], wdone[u], rdy[u]);
        end
        return;
      end
      @(negedge clk);
      done[u] = 1'b0;
      if (i == nb - 1) begin
        total++;
        if (wdone[u] !== 1'b1 || busy[u] !== 1'b1 || rdy[u] !== 1'b0 || txr[u] !== 1'b0 || txd[u] !== exp_q[i]) begin
          bad++;
          $display("FAIL finish u=%0d got wdone=%b busy=%b rdy=%b txr=%b data=%h exp 1 1 0 0 %h",
                   u, wdone[u], busy[u], rdy[u], txr[u], txd[u], exp_q[i]);
        end
        @(negedge clk);
        total++;
        if (rdy[u] !== 1'b1 || wdone[u] !== 1'b0 || busy[u] !== 1'b0 || txr[u] !== 1'b0) begin
          bad++;
          $display("FAIL ready_return u=%0d got rdy=%b wdone=%b busy=%b txr=%b exp 1 0 0 0", u, rdy[u], wdone[u], busy[u], txr[u]);
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      total++;
      if (rdy[u] !== 1'b1 || txr[u] !== 1'b0 || txd[u] !== 8'h00 || busy[u] !== 1'b0 || wdone[u] !== 1'b0) begin
        bad++;
        $display("FAIL reset_state u=%0d got rdy=%b txr=%b data=%h busy=%b wdone=%b exp 1 0 00 0 0",
                 u, rdy[u], txr[u], txd[u], busy[u], wdone[u]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lsb_first();
    send_word(0, 32'h0000FFA3, 4, 1'b0, 20, 1'b0, 1'b0, 32'h0, 0);
  endtask

  task automatic test_msb_first();
    send_word(1, 32'h12345678, 4, 1'b1, 0, 1'b0, 1'b0, 32'h0, 0);
  endtask

  task automatic test_stale_done();
    done[0] = 1'b1;
    @(negedge clk);
    done[0] = 1'b0;
    @(negedge clk);
    total++;
    if (rdy[0] !== 1'b1 || busy[0] !== 1'b0 || txr[0] !== 1'b0) begin
      bad++;
      $display("FAIL stale_idle got rdy=%b busy=%b txr=%b exp 1 0 0", rdy[0], busy[0], txr[0]);
    end
    send_word(0, $urandom, 4, 1'b0, 0, 1'b1, 1'b0, 32'h0, 0);
  endtask

  task automatic test_held_valid();
    send_word(0, $urandom, 4, 1'b0, 0, 1'b0, 1'b1, 32'hDEADBEEF, 0);
    send_word(0, 32'hDEADBEEF, 4, 1'b0, 0, 1'b0, 1'b0, 32'h0, 0);
  endtask

  task automatic test_reset_mid_word();
    send_word(0, $urandom | 32'h0100_0000, 4, 1'b0, 0, 1'b0, 1'b0, 32'h0, 2);
    repeat (3) begin
      @(negedge clk);
      total++;
      if (txr[0] !== 1'b0 || wdone[0] !== 1'b0 || txd[0] !== 8'h00) begin
        bad++;
        $display("FAIL reset_hold got txr=%b wdone=%b data=%h exp 0 0 00", txr[0], wdone[0], txd[0]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    send_word(0, 32'h00000001, 4, 1'b0, 0, 1'b0, 1'b0, 32'h0, 0);
  endtask

  task automatic test_nb16();
    send_word(2, 32'h0000BEEF, 2, 1'b0, 0, 1'b0, 1'b0, 32'h0, 0);
  endtask

  task automatic test_random_words();
    for (int r = 0; r < 6; r++) begin
      int u;
      u = r % 3;
      send_word(u, u == 2 ? $urandom & 32'hFFFF : $urandom, u == 2 ? 2 : 4, u == 1, 0, 1'b0, 1'b0, 32'h0, 0);
    end
  endtask

  initial begin
    for (int u = 0; u < 3; u++) begin
      vld[u] = 1'b0;
      wrd[u] = '0;
      done[u] = 1'b0;
    end
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_stale_done();
    test_held_valid();
    test_reset_mid_word();
    test_nb16();
    test_random_words();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
